// File: rtl/music_pkg.sv
// Shared constants and types for the music note arbiter.
package music_pkg;

    localparam int unsigned NOTE_REST = 25;
    localparam int unsigned TMR_W     = 25;

    localparam logic [1:0] SRC_MENU = 2'd0;
    localparam logic [1:0] SRC_GAME = 2'd1;
    localparam logic [1:0] SRC_SFX  = 2'd2;
    localparam logic [1:0] SRC_NONE = 2'd3;

    typedef enum logic [1:0] {
        ST_BG  = 2'd0,
        ST_SFX = 2'd1,
        ST_GAP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/music_tick_timer.sv
// One-shot down-counter: start loads load_val, done is high on the last counted cycle.
module music_tick_timer
    import music_pkg::*;
#(
    parameter int unsigned         W       = TMR_W,
    parameter logic [W-1:0]        RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] load_val,
    input  logic         start,
    output logic         done
);

    logic [W-1:0] cnt;

    // Saturates at zero so an idle timer never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RST_VAL;
        end else if (start) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == W'(1));

endmodule

// File: rtl/music_note_arbiter.sv
// Arbitrates menu/game background music and sound effects onto one note stream.
// Optional one-deep pending effect slot: define SFX_QUEUE_EN.
module music_note_arbiter
    import music_pkg::*;
#(
    parameter int unsigned NOTE_W   = 5,
    parameter int unsigned STEP_CYC = 6000000,
    parameter int unsigned GAP_CYC  = 600000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NOTE_W-1:0] menu_note,
    input  logic [NOTE_W-1:0] game_note,
    input  logic              mode_game,
    input  logic              sfx_req,
    input  logic [NOTE_W-1:0] sfx_note,
    input  logic [3:0]        sfx_len,
    input  logic              mute,
    output logic              sfx_ack,
    output logic              sfx_busy,
    output logic [NOTE_W-1:0] note_out,
    output logic [1:0]        src
);

    localparam logic [NOTE_W-1:0] REST     = NOTE_W'(NOTE_REST);
    localparam logic [TMR_W-1:0]  LOAD_STP = TMR_W'(STEP_CYC);
    localparam logic [TMR_W-1:0]  LOAD_GAP = TMR_W'(GAP_CYC);

    function automatic logic [NOTE_W-1:0] sat_note(input logic [NOTE_W-1:0] n);
        return (n > REST) ? REST : n;
    endfunction

    arb_state_t state, state_n;

    logic              mode_r;
    logic [NOTE_W-1:0] cur_note;
    logic [3:0]        cur_len;
    logic [3:0]        step_cnt;

    logic              accept;
    logic              sfx_end;
    logic              load_new;
    logic              step_adv;
    logic              ack_d;
    logic              tmr_start;
    logic [TMR_W-1:0]  tmr_load;
    logic              tmr_done;
    logic [NOTE_W-1:0] nxt_note;
    logic [NOTE_W-1:0] note_d;
    logic [1:0]        src_d;

`ifdef SFX_QUEUE_EN
    logic              slot_full;
    logic [NOTE_W-1:0] slot_note;
    logic [3:0]        slot_len;
    logic              q_acc;
    logic              load_slot;
    logic              slot_wr;

    assign q_acc = accept && !slot_full;
`endif

    assign accept  = sfx_req && (sfx_len != 4'd0);
    assign sfx_end = tmr_done && (step_cnt == cur_len - 4'd1);

    // One timer serves both phases; in SFX it is re-armed at every step boundary.
    music_tick_timer #(
        .W       (TMR_W),
        .RST_VAL (LOAD_GAP)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_val (tmr_load),
        .start    (tmr_start),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_GAP;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        tmr_start = 1'b0;
        tmr_load  = LOAD_STP;
        load_new  = 1'b0;
        step_adv  = 1'b0;
        ack_d     = 1'b0;
`ifdef SFX_QUEUE_EN
        load_slot = 1'b0;
        slot_wr   = 1'b0;
`endif
        unique case (state)
            ST_BG: begin
                if (accept) begin
                    state_n   = ST_SFX;
                    tmr_start = 1'b1;
                    load_new  = 1'b1;
                    ack_d     = 1'b1;
                end else if (mode_game != mode_r) begin
                    state_n   = ST_GAP;
                    tmr_start = 1'b1;
                    tmr_load  = LOAD_GAP;
                end
            end
            ST_GAP: begin
                if (accept) begin
                    state_n   = ST_SFX;
                    tmr_start = 1'b1;
                    load_new  = 1'b1;
                    ack_d     = 1'b1;
                end else if (tmr_done) begin
                    state_n = ST_BG;
                end
            end
            ST_SFX: begin
                if (sfx_end) begin
`ifdef SFX_QUEUE_EN
                    if (slot_full) begin
                        tmr_start = 1'b1;
                        load_slot = 1'b1;
                    end else if (q_acc) begin
                        tmr_start = 1'b1;
                        load_new  = 1'b1;
                        ack_d     = 1'b1;
                    end else begin
                        state_n   = ST_GAP;
                        tmr_start = 1'b1;
                        tmr_load  = LOAD_GAP;
                    end
`else
                    state_n   = ST_GAP;
                    tmr_start = 1'b1;
                    tmr_load  = LOAD_GAP;
`endif
                end else if (tmr_done) begin
                    step_adv  = 1'b1;
                    tmr_start = 1'b1;
                end
`ifdef SFX_QUEUE_EN
                if (q_acc && !sfx_end) begin
                    slot_wr = 1'b1;
                    ack_d   = 1'b1;
                end
`endif
            end
            default: begin
                state_n = ST_GAP;
            end
        endcase
    end

    always_comb begin
        nxt_note = cur_note;
        if (load_new) begin
            nxt_note = sfx_note;
        end
`ifdef SFX_QUEUE_EN
        else if (load_slot) begin
            nxt_note = slot_note;
        end
`endif
        note_d = REST;
        src_d  = SRC_NONE;
        unique case (state_n)
            ST_BG: begin
                note_d = sat_note(mode_game ? game_note : menu_note);
                src_d  = mode_game ? SRC_GAME : SRC_MENU;
            end
            ST_SFX: begin
                note_d = sat_note(nxt_note);
                src_d  = SRC_SFX;
            end
            default: begin
                note_d = REST;
                src_d  = SRC_NONE;
            end
        endcase
    end

    assign sfx_busy = (state == ST_SFX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_out <= REST;
            src      <= SRC_NONE;
            sfx_ack  <= 1'b0;
            mode_r   <= 1'b0;
            cur_note <= '0;
            cur_len  <= '0;
            step_cnt <= '0;
        end else begin
            note_out <= mute ? REST : note_d;
            src      <= src_d;
            sfx_ack  <= ack_d;
            if (state_n == ST_BG) begin
                mode_r <= mode_game;
            end
            if (load_new) begin
                cur_note <= sfx_note;
                cur_len  <= sfx_len;
                step_cnt <= '0;
            end
`ifdef SFX_QUEUE_EN
            else if (load_slot) begin
                cur_note <= slot_note;
                cur_len  <= slot_len;
                step_cnt <= '0;
            end
`endif
            else if (step_adv) begin
                step_cnt <= step_cnt + 4'd1;
            end
        end
    end

`ifdef SFX_QUEUE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_full <= 1'b0;
            slot_note <= '0;
            slot_len  <= '0;
        end else if (slot_wr) begin
            slot_full <= 1'b1;
            slot_note <= sfx_note;
            slot_len  <= sfx_len;
        end else if (load_slot) begin
            slot_full <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_music_note_arbiter.sv
// Directed bench with a cycle-count model of the arbiter plus literal spot checks.
module tb_music_note_arbiter;

    localparam int STEP = 4;
    localparam int GAP  = 3;
`ifdef SFX_QUEUE_EN
    localparam bit QUEUE = 1'b1;
`else
    localparam bit QUEUE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] menu_note = 5'd7;
    logic [4:0] game_note = 5'd9;
    logic       mode_game = 1'b0;
    logic       sfx_req = 1'b0;
    logic [4:0] sfx_note = 5'd0;
    logic [3:0] sfx_len = 4'd0;
    logic       mute = 1'b0;
    logic       sfx_ack;
    logic       sfx_busy;
    logic [4:0] note_out;
    logic [1:0] src;

    int checks = 0;
    int errors = 0;

    music_note_arbiter #(
        .NOTE_W   (5),
        .STEP_CYC (STEP),
        .GAP_CYC  (GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .menu_note (menu_note),
        .game_note (game_note),
        .mode_game (mode_game),
        .sfx_req   (sfx_req),
        .sfx_note  (sfx_note),
        .sfx_len   (sfx_len),
        .mute      (mute),
        .sfx_ack   (sfx_ack),
        .sfx_busy  (sfx_busy),
        .note_out  (note_out),
        .src       (src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int n);
        return (n > 25) ? 25 : n;
    endfunction

    // Model: phase 0=background, 1=effect, 2=rest; rem = cycles left in the phase.
    int ph = 2, rem = GAP, m_note = 0, q_note = 0, q_len = 0;
    bit m_mode = 0, q_full = 0;
    int e_note = 25, e_src = 3;
    bit e_ack = 0, e_busy = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                ph = 2; rem = GAP; q_full = 0; m_mode = 0;
                e_note = 25; e_src = 3; e_ack = 0; e_busy = 0;
            end else begin
                bit acc, qa;
                acc = sfx_req && (sfx_len != 0);
                e_ack = 0;
                case (ph)
                    0: begin
                        if (acc) begin
                            ph = 1; m_note = sfx_note; rem = sfx_len * STEP; e_ack = 1;
                        end else if (mode_game != m_mode) begin
                            ph = 2; rem = GAP;
                        end
                    end
                    2: begin
                        if (acc) begin
                            ph = 1; m_note = sfx_note; rem = sfx_len * STEP; e_ack = 1;
                        end else if (rem == 1) begin
                            ph = 0; m_mode = mode_game;
                        end else begin
                            rem--;
                        end
                    end
                    default: begin
                        qa = QUEUE && acc && !q_full;
                        if (rem == 1) begin
                            if (q_full) begin
                                m_note = q_note; rem = q_len * STEP; q_full = 0;
                            end else if (qa) begin
                                m_note = sfx_note; rem = sfx_len * STEP; e_ack = 1;
                            end else begin
                                ph = 2; rem = GAP;
                            end
                        end else begin
                            rem--;
                            if (qa) begin
                                q_full = 1; q_note = sfx_note; q_len = sfx_len; e_ack = 1;
                            end
                        end
                    end
                endcase
                if (ph == 0) m_mode = mode_game;
                e_busy = (ph == 1);
                e_src  = (ph == 0) ? int'(m_mode) : (ph == 1) ? 2 : 3;
                e_note = mute ? 25 :
                         (ph == 0) ? sat(m_mode ? int'(game_note) : int'(menu_note)) :
                         (ph == 1) ? sat(m_note) : 25;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("note_out", note_out, e_note);
            chk("src", src, e_src);
            chk("sfx_ack", sfx_ack, e_ack);
            chk("sfx_busy", sfx_busy, e_busy);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic req(input int note, input int len);
        sfx_req = 1'b1; sfx_note = 5'(note); sfx_len = 4'(len);
    endtask

    initial begin
        cyc(2);
        chk("rst_note", note_out, 25);
        chk("rst_src", src, 3);
        chk("rst_ack", sfx_ack, 0);
        chk("rst_busy", sfx_busy, 0);
        rst_n = 1'b1;
        cyc(2);
        chk("boot_gap_note", note_out, 25);
        cyc(1);
        chk("boot_menu_note", note_out, 7);
        chk("boot_menu_src", src, 0);

        cyc(2);
        mode_game = 1'b1;
        cyc(3);
        chk("mode_gap_note", note_out, 25);
        chk("mode_gap_src", src, 3);
        cyc(1);
        chk("game_note", note_out, 9);
        chk("game_src", src, 1);

        cyc(2);
        req(12, 2);
        cyc(1);
        sfx_req = 1'b0;
        chk("sfx_ack_pulse", sfx_ack, 1);
        chk("sfx_note12", note_out, 12);
        chk("sfx_src", src, 2);
        cyc(1);
        chk("sfx_ack_drop", sfx_ack, 0);
        cyc(6);
        chk("sfx_last_cycle", note_out, 12);
        cyc(1);
        chk("sfx_end_gap", src, 3);
        cyc(3);
        chk("sfx_back_bg", note_out, 9);

        req(3, 0);
        cyc(1);
        sfx_req = 1'b0;
        chk("len0_no_ack", sfx_ack, 0);
        chk("len0_note", note_out, 9);
        cyc(2);

        game_note = 5'd28;
        cyc(1);
        chk("sat_note", note_out, 25);
        chk("sat_src", src, 1);
        game_note = 5'd9;
        cyc(1);

        req(14, 2);
        cyc(1);
        sfx_req = 1'b0;
        cyc(2);
        mute = 1'b1;
        cyc(1);
        chk("mute_note", note_out, 25);
        chk("mute_src", src, 2);
        cyc(1);
        mute = 1'b0;
        cyc(1);
        chk("unmute_note", note_out, 14);
        cyc(2);
        chk("mute_sfx_busy", sfx_busy, 1);
        cyc(1);
        chk("mute_sfx_end", src, 3);
        cyc(3);

        req(3, 1);
        cyc(1);
        sfx_req = 1'b0;
        cyc(1);
        req(20, 1);
        cyc(1);
        sfx_req = 1'b0;
        chk("second_req_ack", sfx_ack, QUEUE);
        cyc(2);
`ifdef SFX_QUEUE_EN
        chk("queued_note", note_out, 20);
        chk("queued_src", src, 2);
`else
        chk("no_queue_gap", note_out, 25);
        chk("no_queue_src", src, 3);
`endif
        cyc(8);
        chk("after_second_bg", note_out, 9);

        mode_game = 1'b0;
        req(5, 1);
        cyc(1);
        sfx_req = 1'b0;
        chk("race_sfx_wins", src, 2);
        cyc(4);
        chk("race_gap", src, 3);
        cyc(3);
        chk("race_menu_note", note_out, 7);
        chk("race_menu_src", src, 0);

        mode_game = 1'b1;
        cyc(1);
        req(6, 1);
        cyc(1);
        sfx_req = 1'b0;
        chk("gap_accept_ack", sfx_ack, 1);
        chk("gap_accept_note", note_out, 6);
        cyc(8);

        req(11, 3);
        cyc(1);
        sfx_req = 1'b0;
        cyc(2);
        rst_n = 1'b0;
        #1;
        chk("abort_note", note_out, 25);
        chk("abort_src", src, 3);
        chk("abort_busy", sfx_busy, 0);
        chk("abort_ack", sfx_ack, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        chk("reboot_game", note_out, 9);
        chk("reboot_src", src, 1);
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
